cl_sweep_ctrl: RTL
==================

# cl_sweep_ctrl

Self-checking sweep controller that drives the 2-input/2-bit-select combinational logic cell (`cl`) and captures its output. On `start` it walks all 16 combinations of {sel, a, b}, waits a programmable settle time per vector, samples the cell's `f`, and assembles a 16-bit result table. The table is compared against an expected value and reported with a `done` pulse. The block sits directly upstream of `cl`, driving its inputs, and directly downstream of it, consuming its output.

## Interface
- `SETTLE`, 1: cycles each vector is held before sampling; legal range 1..15.
- `EXPECTED`, 16'hF3E8: golden table; nibble k holds the results for sel=k, with sel0=AND, sel1=OR, sel2=NOT a, sel3=const 1.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin sweep; sampled only in IDLE.
- `f_in`  in  1  output `f` of the `cl` cell.
- `a_out`  out  1  drives `cl.a`.
- `b_out`  out  1  drives `cl.b`.
- `sel_out`  out  2  drives `cl.sel`.
- `busy`  out  1  high from start acceptance through the DONE cycle.
- `done`  out  1  one-cycle pulse when the sweep ends.
- `table_out`  out  16  captured results; bit i = f for vector index i.
- `mismatch`  out  1  `table_out != EXPECTED`; valid from the `done` cycle.

## Operation
- Vector index `idx` is 4 bits, with `sel_out = idx[3:2]`, `a_out = idx[1]` and `b_out = idx[0]`. All three are registered.
- The FSM has four states: IDLE, DRIVE, SAMPLE and DONE.
- **IDLE**
  - `busy` is 0.
  - If `start`=1: next state is DRIVE, `idx` is set to 0, settle counter `cnt` is set to 0, and `table_out` is cleared to 0. `mismatch` is also cleared.
- **DRIVE**
  - Outputs hold vector `idx`.
  - `cnt` increments each cycle. When `cnt == SETTLE-1`, next state is SAMPLE.
- **SAMPLE** (one cycle)
  - `table_out[idx]` takes `f_in`.
  - If `idx == 15`, next state is DONE.
  - Otherwise `idx` increments, `cnt` resets to 0, and next state is DRIVE.
- **DONE** (one cycle)
  - `done` is 1.
  - `mismatch` is registered as (`table_out != EXPECTED`). The compare uses the fully updated table, because the last SAMPLE write lands at the entry edge of DONE.
  - Next state is IDLE.
- `start` is ignored in every state except IDLE; a start during a sweep is neither queued nor restarts it.
- `table_out` and `mismatch` hold their values in IDLE until the next accepted `start`.
- `f_in` is treated as combinational from the driven vector. No synchronizer is used.

## Timing
- Reset values: state IDLE; `idx`, `cnt`, `a_out`, `b_out`, `sel_out`, `busy`, `done`, `table_out` and `mismatch` all 0.
- Reset is synchronous and wins over every other event, including in the same cycle as `start` or mid-sweep. Outputs return to reset values at the next edge, and a partial table is discarded.
- Let `start` be accepted at edge E0. The following then hold:
  - Vector 0 is on the outputs from E0.
  - Each vector occupies SETTLE DRIVE cycles plus 1 SAMPLE cycle.
  - `f_in` is sampled SETTLE+1 edges after the vector was applied.
  - `done` is high in the cycle following edge E0 + 16·(SETTLE+1).
  - `busy` falls at the next edge.
- With SETTLE=1: 32 cycles of sweep, then 1 DONE cycle, so `done` is asserted 33 edges after E0.
- `idx` does not wrap. The SAMPLE at idx=15 exits to DONE, so the outputs remain at vector 15 (sel=3, a=1, b=1) until the next start or reset.
- Back-to-back sweeps are allowed:
  - A `start` held high through DONE is not accepted in DONE.
  - It is accepted in the first IDLE cycle, which gives a minimum 1-cycle gap.

## Test plan
- **Golden sweep:** connect to a correct `cl` model, SETTLE=1, pulse `start` -> `done` after 33 edges, `table_out`=16'hF3E8, `mismatch`=0, `busy` high for exactly 33 cycles.
- **Stuck fault:** `f_in` tied to 0 -> `table_out`=16'h0000 and `mismatch`=1 on the `done` cycle. Repeat with `f_in` tied to 1 -> 16'hFFFF, `mismatch`=1.
- **Settle timing:** SETTLE=3, with a model that updates `f_in` 2 cycles after an input change -> `table_out`=16'hF3E8. The same model with SETTLE=1 must give `mismatch`=1. Also check that `done` arrives 65 edges after start.
- **Vector order:** monitor the outputs -> `{sel_out,a_out,b_out}` steps 0..15 in order, each held SETTLE+1 cycles, and stays at 4'hF after `done`.
- **Ignored start:** pulse `start` again at vector 5 -> the sweep is unaffected, exactly one `done` pulse is produced, and the table is correct.
- **Mid-sweep reset:** assert `reset` for one cycle at vector 9 -> all outputs are 0 next edge and state is IDLE. A new `start` then yields a full, correct 33-cycle sweep.

Source files
------------

// File: rtl/cl_sweep_ctrl_if.sv
// Sweep controller bus: start/status handshake plus the drive and
// capture signals of the cl cell under test.
interface cl_sweep_ctrl_if;
    logic        start;
    logic        f_in;
    logic        a_out;
    logic        b_out;
    logic [1:0]  sel_out;
    logic        busy;
    logic        done;
    logic [15:0] table_out;
    logic        mismatch;

    modport master (
        output start, f_in,
        input  a_out, b_out, sel_out,
        input  busy, done, table_out, mismatch
    );

    modport slave (
        input  start, f_in,
        output a_out, b_out, sel_out,
        output busy, done, table_out, mismatch
    );
endinterface

// File: rtl/cl_sweep_ctrl.sv
// Walks all 16 {sel,a,b} vectors into a cl cell, samples f after a
// settle delay, and compares the captured table with a golden value.
module cl_sweep_ctrl #(
    parameter int          SETTLE   = 1,
    parameter logic [15:0] EXPECTED = 16'hF3E8
) (
    input logic            clk,
    input logic            reset,
    cl_sweep_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic [3:0]  cnt;
    logic [15:0] tbl;
    logic [15:0] tbl_upd;
    logic        mis;
    logic        busy_c;
    logic        done_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (bus.start) state_nxt = DRIVE;
            DRIVE:  if (cnt == LAST_CNT) state_nxt = SAMPLE;
            SAMPLE: state_nxt = (idx == 4'hF) ? DONE : DRIVE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy_c = (state != IDLE);
        done_c = (state == DONE);
    end

    // Table with the current sample merged in; the final compare must
    // see the entry written on the same edge
    always_comb begin
        tbl_upd      = tbl;
        tbl_upd[idx] = bus.f_in;
    end

    // Vector index, settle counter, result table and verdict
    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
            cnt <= '0;
            tbl <= '0;
            mis <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        idx <= '0;
                        cnt <= '0;
                        tbl <= '0;
                        mis <= 1'b0;
                    end
                end
                DRIVE: cnt <= cnt + 4'd1;
                SAMPLE: begin
                    tbl <= tbl_upd;
                    if (idx == 4'hF) begin
                        mis <= (tbl_upd != EXPECTED);
                    end else begin
                        idx <= idx + 4'd1;
                        cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sel_out   = idx[3:2];
    assign bus.a_out     = idx[1];
    assign bus.b_out     = idx[0];
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.table_out = tbl;
    assign bus.mismatch  = mis;
endmodule
